// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Results above the digit range saturate to all nines and raise ovf.
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int MIN_SN = (IN_WIDTH + 3) / 3;
  localparam int SN     = (MIN_SN > DIGITS) ? MIN_SN : DIGITS;
  localparam int SW     = 4 * SN;
  localparam int CW     = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  sh_q, sh_d, sh_nxt;
  logic [SW-1:0]        scr_q, scr_d, scr_adj, scr_nxt;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic                 big;

  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < SN; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    {scr_nxt, sh_nxt} = {scr_adj, sh_q} << 1;
    // any nonzero nibble above the visible digits means overflow
    big = 1'b0;
    for (int i = DIGITS; i < SN; i++) begin
      big = big | (|scr_nxt[4*i +: 4]);
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SHIFT;
          sh_d    = bin_in;
          scr_d   = '0;
          cnt_d   = CW'(IN_WIDTH);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        sh_d  = sh_nxt;
        scr_d = scr_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          ovf_d   = big;
          bcd_d   = big ? {DIGITS{4'h9}}
                        : scr_nxt[4*DIGITS-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: table vectors, back-to-back, reset abort,
// and random values against an arithmetic decimal reference.
module tb_bin_to_bcd_seq;

  localparam int W = 14;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   bin_in = '0;
  logic [4*D-1:0] bcd;
  logic           busy, done, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  bin_to_bcd_seq #(.IN_WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin_in(bin_in),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          v;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int          div;
    if (v > 9999) return 16'h9999;
    r   = '0;
    div = 1;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic conv(input int v, input bit noise);
    int          cyc;
    logic [15:0] held;
    bit          hold_ok;
    start  = 1'b1;
    bin_in = W'(v);
    step();
    start   = 1'b0;
    bin_in  = W'($urandom);
    held    = bcd;
    hold_ok = 1'b1;
    cyc     = 1;
    while (!done && cyc < 40) begin
      if (!busy || bcd !== held) hold_ok = 1'b0;
      if (noise) start = 1'($urandom);
      bin_in = W'($urandom);
      step();
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, 15);
    chk("busy_hold", hold_ok, 1);
    chk("bcd", bcd, ref_bcd(v));
    chk("ovf", ovf, v > 9999);
    chk("busy_in_done", busy, 0);
    step();
    chk("idle_after", {busy, done}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[10];
    logic [W-1:0] q[$];
    logic [W-1:0] r, e;
    bit          seen;
    int          v;

    tbl[0] = '{0,     16'h0000, 1'b0};
    tbl[1] = '{1234,  16'h1234, 1'b0};
    tbl[2] = '{9999,  16'h9999, 1'b0};
    tbl[3] = '{10000, 16'h9999, 1'b1};
    tbl[4] = '{16383, 16'h9999, 1'b1};
    tbl[5] = '{5,     16'h0005, 1'b0};
    tbl[6] = '{42,    16'h0042, 1'b0};
    tbl[7] = '{10,    16'h0010, 1'b0};
    tbl[8] = '{8191,  16'h8191, 1'b0};
    tbl[9] = '{9,     16'h0009, 1'b0};

    rst = 1'b1;
    repeat (3) step();
    chk("rst_outs", {bcd, busy, done, ovf}, 0);
    rst = 1'b0;
    step();
    chk("post_rst_outs", {bcd, busy, done, ovf}, 0);

    for (int i = 0; i < 10; i++) begin
      conv(tbl[i].v, 1'b0);
      chk("tbl_bcd", bcd, tbl[i].bcd);
      chk("tbl_ovf", ovf, tbl[i].ovf);
    end

    start = 1'b1;
    for (int c = 0; c < 75; c++) begin
      r = W'($urandom);
      bin_in = r;
      if (c % 15 == 0) q.push_back(r);
      step();
      chk("b2b_done", done, (c % 15) == 14);
      chk("b2b_busy", busy, (c % 15) != 14);
      if ((c % 15) == 14) begin
        e = q.pop_front();
        chk("b2b_bcd", bcd, ref_bcd(int'(e)));
        chk("b2b_ovf", ovf, int'(e) > 9999);
      end
    end
    start = 1'b0;
    step();
    chk("b2b_idle", {busy, done}, 0);

    conv(10000, 1'b0);
    start  = 1'b1;
    bin_in = W'(42);
    step();
    start = 1'b0;
    repeat (6) step();
    chk("abort_busy_pre", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_bcd", bcd, 0);
    chk("abort_flags", {busy, done, ovf}, 0);
    seen = 1'b0;
    repeat (20) begin
      step();
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    conv(42, 1'b0);
    chk("after_abort_bcd", bcd, 16'h0042);

    repeat (150) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(9980, 10020));
      else v = int'($urandom_range(0, 16383));
      conv(v, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $finish;
  end

endmodule
